uart_result_sender: RTL and testbench

- Upstream feeder for the UART transmitter (8 data bits, 16-tick oversampling).
- When the BIP1 core halts, this block snapshots the accumulator, program counter and cycle counter and builds a fixed 8-byte frame.
- It hands the frame to the transmitter one byte at a time using that transmitter's start/done handshake.
- It holds no baud logic; pacing comes entirely from the transmitter's done tick.

---
 rtl/uart_result_sender.sv | 184 ++++++++++++++++++
 tb/tb_uart_result_sender.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_result_sender.sv
// -----------------------------------------------------------------------------
// uart_result_sender
//
// Feeds the UART transmitter with an 8-byte result frame when the BIP1 core
// halts. On a send request in IDLE it snapshots the accumulator, program
// counter and cycle counter, then hands one byte at a time to the transmitter
// using its start/done handshake. No baud logic lives here; pacing comes
// entirely from the transmitter's done tick.
//
// Frame: HEADER, acc[15:8], acc[7:0], pc[15:8], pc[7:0], cnt[15:8], cnt[7:0],
//        XOR of bytes 1..6 (fields zero-extended to 16 bits).
//
// Ports:
//   i_clk           system clock, rising edge
//   i_reset         asynchronous active-low reset
//   i_send          frame request, sampled only in IDLE
//   i_acc           accumulator value (ACC_W bits)
//   i_pc            program counter value (PC_W bits)
//   i_cnt           executed-cycle count (CNT_W bits)
//   i_tx_done_tick  one-cycle pulse from the transmitter at end of stop bit
//   o_tx_start      one-cycle start pulse to the transmitter
//   o_tx_data       byte presented to the transmitter
//   o_busy          high while a frame is in progress
//   o_done          one-cycle pulse after the last byte completes
// -----------------------------------------------------------------------------
module uart_result_sender #(
  parameter logic [7:0] HEADER = 8'hA5,
  parameter int         ACC_W  = 16,
  parameter int         PC_W   = 11,
  parameter int         CNT_W  = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_send,
  input  logic [ACC_W-1:0] i_acc,
  input  logic [PC_W-1:0]  i_pc,
  input  logic [CNT_W-1:0] i_cnt,
  input  logic             i_tx_done_tick,
  output logic             o_tx_start,
  output logic [7:0]       o_tx_data,
  output logic             o_busy,
  output logic             o_done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [2:0]  idx_r;
  logic [2:0]  idx_next_s;
  logic        capture_s;

  logic [15:0] acc_snap_r;
  logic [15:0] pc_snap_r;
  logic [15:0] cnt_snap_r;
  logic [15:0] acc_snap_next_s;
  logic [15:0] pc_snap_next_s;
  logic [15:0] cnt_snap_next_s;
  logic [7:0]  tx_data_next_s;

  // Checksum byte: XOR of the six payload bytes (header excluded).
  function automatic logic [7:0] frame_checksum(input logic [15:0] acc,
                                                input logic [15:0] pc,
                                                input logic [15:0] cnt);
    return acc[15:8] ^ acc[7:0] ^ pc[15:8] ^ pc[7:0] ^ cnt[15:8] ^ cnt[7:0];
  endfunction

  // Select frame byte idx from the (zero-extended) snapshot fields.
  function automatic logic [7:0] frame_byte(input logic [2:0]  idx,
                                            input logic [15:0] acc,
                                            input logic [15:0] pc,
                                            input logic [15:0] cnt);
    logic [7:0] b;
    case (idx)
      3'd0:    b = HEADER;
      3'd1:    b = acc[15:8];
      3'd2:    b = acc[7:0];
      3'd3:    b = pc[15:8];
      3'd4:    b = pc[7:0];
      3'd5:    b = cnt[15:8];
      3'd6:    b = cnt[7:0];
      3'd7:    b = frame_checksum(acc, pc, cnt);
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Next-state and byte-index logic; capture only happens on a request in IDLE.
  always_comb begin
    state_next_s = state_r;
    idx_next_s   = idx_r;
    capture_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_send) begin
          state_next_s = ST_SEND;
          idx_next_s   = 3'd0;
          capture_s    = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        state_next_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_tx_done_tick) begin
          if (idx_r == 3'd7) begin
            // Last byte finished: index stays at 7, DONE is entered instead of wrapping.
            state_next_s = ST_DONE;
          end else begin
            state_next_s = ST_SEND;
            idx_next_s   = idx_r + 3'd1;
          end
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
        idx_next_s   = 3'd0;
      end
    endcase
  end

  // Snapshot next values and the byte the transmitter will see next cycle.
  always_comb begin
    acc_snap_next_s = acc_snap_r;
    pc_snap_next_s  = pc_snap_r;
    cnt_snap_next_s = cnt_snap_r;
    if (capture_s) begin
      acc_snap_next_s = 16'(i_acc);
      pc_snap_next_s  = 16'(i_pc);
      cnt_snap_next_s = 16'(i_cnt);
    end else begin
      acc_snap_next_s = acc_snap_r;
      pc_snap_next_s  = pc_snap_r;
      cnt_snap_next_s = cnt_snap_r;
    end
    tx_data_next_s = frame_byte(idx_next_s, acc_snap_next_s, pc_snap_next_s, cnt_snap_next_s);
  end

  // FSM state and byte index registers.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_r <= ST_IDLE;
      idx_r   <= 3'd0;
    end else begin
      state_r <= state_next_s;
      idx_r   <= idx_next_s;
    end
  end

  // Snapshot registers and registered outputs, decoded from the next state so
  // each output is aligned with the state it belongs to.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      acc_snap_r <= 16'h0000;
      pc_snap_r  <= 16'h0000;
      cnt_snap_r <= 16'h0000;
      o_tx_start <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_tx_data  <= 8'h00;
    end else begin
      acc_snap_r <= acc_snap_next_s;
      pc_snap_r  <= pc_snap_next_s;
      cnt_snap_r <= cnt_snap_next_s;
      o_tx_start <= (state_next_s == ST_SEND);
      o_busy     <= (state_next_s != ST_IDLE);
      o_done     <= (state_next_s == ST_DONE);
      o_tx_data  <= tx_data_next_s;
    end
  end

endmodule

// File: tb/tb_uart_result_sender.sv
// -----------------------------------------------------------------------------
// tb_uart_result_sender
//
// Self-checking bench for uart_result_sender. A behavioural transmitter stand-in
// returns done ticks after a chosen delay; expected frames come from a simple
// arithmetic model of the frame layout (or literal byte lists).
// -----------------------------------------------------------------------------
module tb_uart_result_sender;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_send;
  logic [15:0] i_acc;
  logic [10:0] i_pc;
  logic [15:0] i_cnt;
  logic        i_tx_done_tick;
  logic        o_tx_start;
  logic [7:0]  o_tx_data;
  logic        o_busy;
  logic        o_done;

  int n_tests = 0;
  int n_fail  = 0;
  int n_starts = 0;
  int n_dones  = 0;
  logic [7:0] exp_bytes [8];

  always #5 clk = ~clk;

  uart_result_sender #(
    .HEADER(8'hA5), .ACC_W(16), .PC_W(11), .CNT_W(16)
  ) dut (
    .i_clk(clk), .i_reset(i_reset), .i_send(i_send),
    .i_acc(i_acc), .i_pc(i_pc), .i_cnt(i_cnt),
    .i_tx_done_tick(i_tx_done_tick),
    .o_tx_start(o_tx_start), .o_tx_data(o_tx_data),
    .o_busy(o_busy), .o_done(o_done)
  );

  // Count start and done pulses seen on the outputs.
  always @(posedge clk) begin
    if (o_tx_start) n_starts <= n_starts + 1;
    if (o_done)     n_dones  <= n_dones + 1;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference frame from the field values using plain arithmetic.
  task automatic model_frame(input int acc, input int pc, input int cnt);
    int a, p, c, ck;
    a = acc % 65536;
    p = pc % 2048;
    c = cnt % 65536;
    exp_bytes[0] = 8'hA5;
    exp_bytes[1] = 8'(a / 256);
    exp_bytes[2] = 8'(a % 256);
    exp_bytes[3] = 8'(p / 256);
    exp_bytes[4] = 8'(p % 256);
    exp_bytes[5] = 8'(c / 256);
    exp_bytes[6] = 8'(c % 256);
    ck = 0;
    for (int k = 1; k <= 6; k++) ck = ck ^ int'(exp_bytes[k]);
    exp_bytes[7] = 8'(ck);
  endtask

  task automatic load_bytes(input logic [63:0] v);
    for (int k = 0; k < 8; k++) exp_bytes[k] = v[63-8*k -: 8];
  endtask

  // Issue a request from IDLE; returns in the SEND cycle of byte 0.
  task automatic start_frame(input int acc, input int pc, input int cnt, input bit hold);
    i_acc  = 16'(acc);
    i_pc   = 11'(pc);
    i_cnt  = 16'(cnt);
    i_send = 1'b1;
    @(posedge clk); #1;
    check_eq("start_after_send", 32'(o_tx_start), 32'd1);
    check_eq("busy_after_capture", 32'(o_busy), 32'd1);
    i_send = hold;
    if (!hold) begin
      i_acc = 16'($urandom);
      i_pc  = 11'($urandom);
      i_cnt = 16'($urandom);
    end
  endtask

  // Walk the 8 bytes acting as the transmitter. Entered in a SEND cycle.
  task automatic frame_body(input int delay, input bit spurious, input bit busy_send,
                            input int abort_byte, output bit aborted);
    aborted = 1'b0;
    for (int b = 0; b < 8; b++) begin
      check_eq("data_at_start", 32'(o_tx_data), 32'(exp_bytes[b]));
      if (spurious && b == 0) i_tx_done_tick = 1'b1;
      for (int i = 1; i <= delay; i++) begin
        @(posedge clk); #1;
        i_tx_done_tick = (i == delay);
        if (busy_send && b == 3) begin
          i_send = (i == 1);
          if (i == 1) i_acc = 16'hFFFF;
        end
        check_eq("start_low_in_wait", 32'(o_tx_start), 32'd0);
        check_eq("busy_in_wait", 32'(o_busy), 32'd1);
        check_eq("data_stable", 32'(o_tx_data), 32'(exp_bytes[b]));
        if (b == abort_byte && i == 2) begin
          i_reset = 1'b0;
          #1;
          check_eq("abort_start", 32'(o_tx_start), 32'd0);
          check_eq("abort_busy", 32'(o_busy), 32'd0);
          check_eq("abort_done", 32'(o_done), 32'd0);
          check_eq("abort_data", 32'(o_tx_data), 32'd0);
          i_tx_done_tick = 1'b0;
          @(posedge clk); #1;
          i_reset = 1'b1;
          aborted = 1'b1;
          return;
        end
      end
      @(posedge clk); #1;
      i_tx_done_tick = 1'b0;
      if (b < 7) begin
        check_eq("start_one_after_tick", 32'(o_tx_start), 32'd1);
        check_eq("busy_in_send", 32'(o_busy), 32'd1);
      end else begin
        check_eq("done_pulse", 32'(o_done), 32'd1);
        check_eq("busy_in_done", 32'(o_busy), 32'd1);
        check_eq("no_start_in_done", 32'(o_tx_start), 32'd0);
      end
    end
  endtask

  // After DONE with no pending request: idle, no further starts.
  task automatic idle_check(input int s0, input int d0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_eq("idle_busy", 32'(o_busy), 32'd0);
      check_eq("idle_start", 32'(o_tx_start), 32'd0);
      check_eq("idle_done", 32'(o_done), 32'd0);
    end
    check_eq("start_count", 32'(n_starts - s0), 32'd8);
    check_eq("done_count", 32'(n_dones - d0), 32'd1);
  endtask

  initial begin
    bit ab;
    int s0, d0, acc, pc, cnt;
    i_reset = 1'b0; i_send = 1'b0; i_tx_done_tick = 1'b0;
    i_acc = 16'h0; i_pc = 11'h0; i_cnt = 16'h0;
    #3;
    check_eq("rst_start", 32'(o_tx_start), 32'd0);
    check_eq("rst_busy", 32'(o_busy), 32'd0);
    check_eq("rst_done", 32'(o_done), 32'd0);
    check_eq("rst_data", 32'(o_tx_data), 32'd0);
    repeat (3) @(posedge clk);
    #1 i_reset = 1'b1;
    @(posedge clk); #1;

    // Basic frame, 20-cycle transmitter.
    load_bytes(64'hA5_12_34_02_AB_00_FF_70);
    s0 = n_starts; d0 = n_dones;
    start_frame(32'h1234, 32'h2AB, 32'h00FF, 1'b0);
    frame_body(20, 1'b0, 1'b0, -1, ab);
    idle_check(s0, d0);

    // Busy rejection: second request during byte 3 is ignored.
    s0 = n_starts; d0 = n_dones;
    start_frame(32'h1234, 32'h2AB, 32'h00FF, 1'b0);
    frame_body(20, 1'b0, 1'b1, -1, ab);
    idle_check(s0, d0);

    // Spurious ticks in IDLE and in the SEND cycle.
    i_tx_done_tick = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    i_tx_done_tick = 1'b0;
    check_eq("spur_idle_busy", 32'(o_busy), 32'd0);
    check_eq("spur_idle_start", 32'(o_tx_start), 32'd0);
    load_bytes(64'hA5_00_00_07_FF_00_00_F8);
    s0 = n_starts; d0 = n_dones;
    start_frame(32'h0, 32'h7FF, 32'h0, 1'b0);
    frame_body(5, 1'b1, 1'b0, -1, ab);
    idle_check(s0, d0);

    // Reset during WAIT of byte 4, then a full new frame.
    acc = int'($urandom_range(0, 65535)); pc = int'($urandom_range(0, 2047));
    cnt = int'($urandom_range(0, 65535));
    model_frame(acc, pc, cnt);
    start_frame(acc, pc, cnt, 1'b0);
    frame_body(6, 1'b0, 1'b0, 4, ab);
    check_eq("aborted_flag", 32'(ab), 32'd1);
    check_eq("after_abort_busy", 32'(o_busy), 32'd0);
    acc = int'($urandom_range(0, 65535)); pc = int'($urandom_range(0, 2047));
    cnt = int'($urandom_range(0, 65535));
    model_frame(acc, pc, cnt);
    s0 = n_starts; d0 = n_dones;
    start_frame(acc, pc, cnt, 1'b0);
    frame_body(4, 1'b0, 1'b0, -1, ab);
    idle_check(s0, d0);

    // Held request: back-to-back frames, one IDLE cycle between.
    acc = int'($urandom_range(0, 65535)); pc = int'($urandom_range(0, 2047));
    cnt = int'($urandom_range(0, 65535));
    model_frame(acc, pc, cnt);
    start_frame(acc, pc, cnt, 1'b1);
    for (int f = 0; f < 3; f++) begin
      frame_body(3, 1'b0, 1'b0, -1, ab);
      if (f == 2) i_send = 1'b0;
      @(posedge clk); #1;
      check_eq("held_idle_busy", 32'(o_busy), 32'd0);
      check_eq("held_idle_start", 32'(o_tx_start), 32'd0);
      if (f < 2) begin
        @(posedge clk); #1;
        check_eq("held_restart", 32'(o_tx_start), 32'd1);
        check_eq("held_restart_busy", 32'(o_busy), 32'd1);
      end
    end
    @(posedge clk); #1;
    check_eq("held_end_start", 32'(o_tx_start), 32'd0);

    // Randomized frames and transmitter delays.
    for (int r = 0; r < 6; r++) begin
      acc = int'($urandom_range(0, 65535)); pc = int'($urandom_range(0, 2047));
      cnt = int'($urandom_range(0, 65535));
      model_frame(acc, pc, cnt);
      s0 = n_starts; d0 = n_dones;
      start_frame(acc, pc, cnt, 1'b0);
      frame_body(int'($urandom_range(1, 12)), 1'b0, 1'b0, -1, ab);
      idle_check(s0, d0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
